// File: rtl/pdm_interp_tx.sv
// PCM-to-PDM transmitter: sample FIFO, per-tick upsampler and 2nd-order sigma-delta modulator.
// Define PDM_LINEAR_INTERP_EN for linear interpolation between samples; default is zero-order hold.
//
// state  | meaning
// S_IDLE | no sample loaded yet; modulator input forced to 0
// S_RUN  | stepping through segments between prev and next on each tick
module pdm_interp_tx #(
    parameter int WIDTH            = 16,
    parameter int TICKS_PER_SAMPLE = 256,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          tick_in,
    input  logic [WIDTH-1:0]              sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic                          pdm_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);
    localparam int SHIFT = $clog2(TICKS_PER_SAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int I1_W  = WIDTH + 4;
    localparam int I2_W  = WIDTH + 8;
    localparam int SUM_W = WIDTH + 10;

    localparam logic signed [SUM_W-1:0] FB_POS = SUM_W'(1) <<< (WIDTH - 1);
    localparam logic signed [SUM_W-1:0] FB_NEG = -FB_POS;
    localparam logic signed [SUM_W-1:0] I1_MAX = (SUM_W'(1) <<< (I1_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] I1_MIN = -(SUM_W'(1) <<< (I1_W - 1));
    localparam logic signed [SUM_W-1:0] I2_MAX = (SUM_W'(1) <<< (I2_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] I2_MIN = -(SUM_W'(1) <<< (I2_W - 1));

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t state, state_nxt;
    logic start, boundary, pop, push, empty;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rd_data;

    logic [SHIFT-1:0]        k;
    logic signed [WIDTH-1:0] prev, next, x;

    logic signed [I1_W-1:0]  i1, i1_new;
    logic signed [I2_W-1:0]  i2, i2_new;
    logic signed [SUM_W-1:0] fb, i1_sum, i2_sum;

    assign empty            = (count == '0);
    assign sample_ready_out = (count != CNT_W'(FIFO_DEPTH));
    assign push             = sample_valid_in && sample_ready_out;
    assign fifo_count_out   = count;
    assign rd_data          = mem[rd_ptr];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        boundary     = 1'b0;
        pop          = 1'b0;
        underrun_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    start     = 1'b1;
                    pop       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                boundary     = tick_in && (&k);
                pop          = boundary && !empty;
                underrun_out = boundary && empty;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // k wraps to zero on its own at the boundary because TICKS_PER_SAMPLE is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            k    <= '0;
            prev <= '0;
            next <= '0;
        end else if (start) begin
            k    <= '0;
            prev <= '0;
            next <= rd_data;
        end else if (state == S_RUN && tick_in) begin
            k <= k + SHIFT'(1);
            if (boundary) begin
                prev <= next;
                if (!empty) next <= rd_data;
            end
        end
    end

`ifdef PDM_LINEAR_INTERP_EN
    localparam int ACC_W = WIDTH + SHIFT + 1;

    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH:0]   delta;

    assign delta = {next[WIDTH-1], next} - {prev[WIDTH-1], prev};

    // On an underrun next is retained, so reloading from it holds the last sample flat.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (state == S_RUN && tick_in) begin
            if (boundary) acc <= ACC_W'(next) <<< SHIFT;
            else          acc <= acc + ACC_W'(delta);
        end
    end

    assign x = (state == S_RUN) ? acc[SHIFT +: WIDTH] : '0;
`else
    assign x = (state == S_RUN) ? prev : '0;
`endif

    always_comb begin
        fb     = pdm_out ? FB_POS : FB_NEG;
        i1_sum = SUM_W'(i1) + SUM_W'(x) - fb;
        if (i1_sum > I1_MAX)      i1_new = I1_W'(I1_MAX);
        else if (i1_sum < I1_MIN) i1_new = I1_W'(I1_MIN);
        else                      i1_new = I1_W'(i1_sum);
        i2_sum = SUM_W'(i2) + SUM_W'(i1_new) - fb;
        if (i2_sum > I2_MAX)      i2_new = I2_W'(I2_MAX);
        else if (i2_sum < I2_MIN) i2_new = I2_W'(I2_MIN);
        else                      i2_new = I2_W'(i2_sum);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            i1      <= '0;
            i2      <= '0;
            pdm_out <= 1'b0;
        end else if (tick_in) begin
            i1      <= i1_new;
            i2      <= i2_new;
            pdm_out <= ~i2_new[I2_W-1];
        end
    end

endmodule

// File: tb/tb_pdm_interp_tx.sv
// Directed self-checking bench for pdm_interp_tx: FIFO handshake, segment timing,
// interpolation values, modulator density and asynchronous reset.
module tb_pdm_interp_tx;
    logic        clk_in = 1'b0;
    logic        rst_in, tick_in, sample_valid_in;
    logic [15:0] sample_in;
    logic        sample_ready_out, pdm_out, underrun_out;
    logic [2:0]  fifo_count_out;

    int n_checks = 0;
    int n_fail   = 0;
    int ones, underruns, drops, max_count, pdm_glitch;
    logic [2:0] last_count;

    pdm_interp_tx #(.WIDTH(16), .TICKS_PER_SAMPLE(256), .FIFO_DEPTH(4)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .tick_in          (tick_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .pdm_out          (pdm_out),
        .underrun_out     (underrun_out),
        .fifo_count_out   (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    // One clock cycle with tick_in = t; underrun is sampled mid-cycle, the rest after the edge.
    task automatic step(input logic t);
        logic pdm_before;
        pdm_before = pdm_out;
        tick_in = t;
        @(negedge clk_in);
        if (underrun_out === 1'b1) underruns++;
        @(posedge clk_in);
        #1;
        if (t && pdm_out === 1'b1) ones++;
        if (!t && pdm_out !== pdm_before) pdm_glitch++;
        if (fifo_count_out < last_count) drops++;
        if (int'(fifo_count_out) > max_count) max_count = int'(fifo_count_out);
        last_count = fifo_count_out;
        tick_in = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    task automatic clear_stats();
        ones = 0; underruns = 0; drops = 0; max_count = 0; pdm_glitch = 0;
    endtask

    task automatic do_reset();
        tick_in = 1'b0;
        sample_valid_in = 1'b0;
        #2 rst_in = 1'b0;
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        last_count = '0;
    endtask

    task automatic test_reset();
        logic signed [15:0] xv;
        rst_in = 1'b0;
        tick_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        xv = dut.x;
        n_checks++; if (pdm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pdm: got %b want 0", pdm_out); end
        n_checks++; if (underrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun_out); end
        n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count_out); end
        n_checks++; if (sample_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sample_ready_out); end
        n_checks++; if (xv !== 16'sd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", xv); end
        tick_in = 1'b0;
        @(negedge clk_in) rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        last_count = '0;
    endtask

    task automatic test_idle();
        do_reset();
        clear_stats();
        run_ticks(1024);
        n_checks++; if (ones < 510 || ones > 514) begin n_fail++; $display("FAIL idle_ones: got %0d want 510..514", ones); end
        n_checks++; if (underruns !== 0) begin n_fail++; $display("FAIL idle_underrun: got %0d pulses want 0", underruns); end
        n_checks++; if (sample_ready_out !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", sample_ready_out); end
        n_checks++; if (pdm_glitch !== 0) begin n_fail++; $display("FAIL idle_stable: got %0d changes off-tick want 0", pdm_glitch); end
    endtask

    task automatic test_const_fill();
        do_reset();
        sample_in = 16'd16384;
        sample_valid_in = 1'b1;
        clear_stats();
        run_ticks(512);
        n_checks++; if (max_count !== 4) begin n_fail++; $display("FAIL fill_max: got %0d want 4", max_count); end
        n_checks++; if (fifo_count_out !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", fifo_count_out); end
        n_checks++; if (sample_ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", sample_ready_out); end
        for (int w = 0; w < 2; w++) begin
            clear_stats();
            run_ticks(256);
            if (w == 0) begin
                n_checks++; if (ones < 190 || ones > 194) begin n_fail++; $display("FAIL const_ones: got %0d want 190..194", ones); end
            end
            n_checks++; if (drops !== 1) begin n_fail++; $display("FAIL const_pops w%0d: got %0d want 1", w, drops); end
            n_checks++; if (underruns !== 0) begin n_fail++; $display("FAIL const_underrun w%0d: got %0d want 0", w, underruns); end
        end
        sample_valid_in = 1'b0;
    endtask

    task automatic test_full_scale();
        do_reset();
        sample_in = 16'd32767;
        sample_valid_in = 1'b1;
        run_ticks(512);
        clear_stats();
        run_ticks(1024);
        n_checks++; if (ones < 1014) begin n_fail++; $display("FAIL pos_full_ones: got %0d want >=1014", ones); end
        n_checks++; if (pdm_glitch !== 0) begin n_fail++; $display("FAIL pos_full_stable: got %0d want 0", pdm_glitch); end
        do_reset();
        sample_in = 16'h8000;
        sample_valid_in = 1'b1;
        run_ticks(512);
        clear_stats();
        run_ticks(1024);
        n_checks++; if (ones > 10) begin n_fail++; $display("FAIL neg_full_ones: got %0d want <=10", ones); end
        sample_valid_in = 1'b0;
    endtask

    task automatic test_interp();
        logic signed [15:0] xv, want;
        do_reset();
        sample_valid_in = 1'b1;
        sample_in = 16'd0;
        step(1'b0);
        sample_in = 16'd8192;
        step(1'b0);
        sample_valid_in = 1'b0;
        n_checks++; if (fifo_count_out !== 3'd1) begin n_fail++; $display("FAIL interp_queued: got %0d want 1", fifo_count_out); end
        clear_stats();
        for (int j = 0; j < 256; j++) begin
            if (j == 0 || j == 128 || j == 255) begin
                xv = dut.x;
                n_checks++; if (xv !== 16'sd0) begin n_fail++; $display("FAIL interp_seg1 j=%0d: got %0d want 0", j, xv); end
            end
            step(1'b1);
            step(1'b0);
        end
        n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL interp_popped: got %0d want 0", fifo_count_out); end
        clear_stats();
        for (int j = 0; j < 256; j++) begin
            xv = dut.x;
`ifdef PDM_LINEAR_INTERP_EN
            want = 16'(j * 32);
`else
            want = 16'sd0;
`endif
            n_checks++; if (xv !== want) begin n_fail++; $display("FAIL interp_seg2 j=%0d: got %0d want %0d", j, xv, want); end
            step(1'b1);
            step(1'b0);
        end
        xv = dut.x;
        n_checks++; if (xv !== 16'sd8192) begin n_fail++; $display("FAIL interp_seg3: got %0d want 8192", xv); end
        n_checks++; if (underruns !== 1) begin n_fail++; $display("FAIL interp_underrun: got %0d want 1", underruns); end
    endtask

    task automatic test_underrun();
        do_reset();
        sample_valid_in = 1'b1;
        sample_in = 16'd4096;
        step(1'b0);
        sample_valid_in = 1'b0;
        step(1'b0);
        n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL ur_start_pop: got %0d want 0", fifo_count_out); end
        clear_stats();
        run_ticks(255);
        n_checks++; if (underruns !== 0) begin n_fail++; $display("FAIL ur_early: got %0d want 0", underruns); end
        run_ticks(1);
        n_checks++; if (underruns !== 1) begin n_fail++; $display("FAIL ur_first: got %0d want 1", underruns); end
        clear_stats();
        run_ticks(1024);
        n_checks++; if (underruns !== 4) begin n_fail++; $display("FAIL ur_count: got %0d want 4", underruns); end
        n_checks++; if (ones < 572 || ones > 580) begin n_fail++; $display("FAIL ur_density: got %0d want 572..580", ones); end
        n_checks++; if (pdm_glitch !== 0) begin n_fail++; $display("FAIL ur_stable: got %0d want 0", pdm_glitch); end
    endtask

    task automatic test_mid_reset();
        logic signed [15:0] xv;
        do_reset();
        sample_valid_in = 1'b1;
        sample_in = 16'd4096;
        repeat (4) step(1'b0);
        sample_valid_in = 1'b0;
        n_checks++; if (fifo_count_out !== 3'd3) begin n_fail++; $display("FAIL mr_queued: got %0d want 3", fifo_count_out); end
        run_ticks(100);
        for (int j = 0; j < 16 && pdm_out !== 1'b1; j++) step(1'b1);
        n_checks++; if (pdm_out !== 1'b1) begin n_fail++; $display("FAIL mr_pre_pdm: got %b want 1 within 16 ticks", pdm_out); end
        #2 rst_in = 1'b0;
        #1;
        n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL mr_async_count: got %0d want 0", fifo_count_out); end
        n_checks++; if (pdm_out !== 1'b0) begin n_fail++; $display("FAIL mr_async_pdm: got %b want 0", pdm_out); end
        n_checks++; if (sample_ready_out !== 1'b1) begin n_fail++; $display("FAIL mr_async_ready: got %b want 1", sample_ready_out); end
        @(negedge clk_in) rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        last_count = '0;
        clear_stats();
        run_ticks(1024);
        n_checks++; if (ones < 510 || ones > 514) begin n_fail++; $display("FAIL mr_idle_ones: got %0d want 510..514", ones); end
        n_checks++; if (underruns !== 0) begin n_fail++; $display("FAIL mr_idle_underrun: got %0d want 0", underruns); end
        sample_valid_in = 1'b1;
        sample_in = 16'd8192;
        step(1'b0);
        sample_valid_in = 1'b0;
        n_checks++; if (fifo_count_out !== 3'd1) begin n_fail++; $display("FAIL mr_push: got %0d want 1", fifo_count_out); end
        step(1'b0);
        xv = dut.x;
        n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL mr_idle_pop: got %0d want 0", fifo_count_out); end
        n_checks++; if (xv !== 16'sd0) begin n_fail++; $display("FAIL mr_first_x: got %0d want 0", xv); end
    endtask

    initial begin
        rst_in = 1'b0;
        tick_in = 1'b0;
        sample_valid_in = 1'b0;
        sample_in = '0;
        last_count = '0;
        clear_stats();
        test_reset();
        test_idle();
        test_const_fill();
        test_full_scale();
        test_interp();
        test_underrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pdm_interp_tx.md
# pdm_interp_tx

Audio-output end of the PDM chain: accepts 16-bit signed PCM samples at the decimated rate over a valid/ready handshake and buffers them in a small FIFO. It upsamples each sample to the PDM tick rate, by linear interpolation or zero-order hold, and drives a second-order sigma-delta modulator. The resulting 1-bit stream feeds spkl/spkr, mirroring the mic-side decimation chain.

## Interface
- WIDTH, 16, sample width (signed two's complement)
- TICKS_PER_SAMPLE, 256, PDM ticks per input sample; power of two, ≥ 2
- FIFO_DEPTH, 4, sample FIFO entries; power of two, ≥ 2
- clk_in  input  1  system clock (clk_m domain)
- rst_in  input  1  asynchronous, active-low reset
- tick_in  input  1  single-cycle PDM step enable (mic-clock rising-edge pulse)
- sample_in  input  WIDTH  signed PCM sample
- sample_valid_in  input  1  sample_in valid
- sample_ready_out  output  1  FIFO can accept; combinational, = (count != FIFO_DEPTH)
- pdm_out  output  1  PDM bitstream, registered
- underrun_out  output  1  one-cycle pulse: segment boundary found FIFO empty
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Push when sample_valid_in && sample_ready_out. Pop only at segment boundaries, defined below.
- Simultaneous push and pop leaves the count unchanged. A push to a full FIFO is impossible because ready is low.
- Registers:
  - prev, next: WIDTH-bit signed samples
  - acc: WIDTH+log2(TICKS_PER_SAMPLE)+1 bits signed
  - k: tick counter over 0..TICKS_PER_SAMPLE-1
- FSM states:
  - S_IDLE (reset state):
    - Modulator input is 0; k holds at 0.
    - On the first cycle with count > 0: pop into next, set prev=0, acc=0, k=0, and go to S_RUN. No tick_in is required.
  - S_RUN: on each tick_in, k increments and the interpolated value x is presented to the modulator.
  - Segment boundary = a tick_in with k == TICKS_PER_SAMPLE-1:
    - If FIFO non-empty: prev←next, next←pop, acc←next<<<log2(N), k←0.
    - If FIFO empty: prev←next (next retained), pulse underrun_out, k←0, stay in S_RUN. The output holds the last sample.
- Interpolation (LINEAR_INTERP_EN defined):
  - delta = next − prev, sign-extended to WIDTH+1 bits.
  - acc += delta per tick; acc starts at prev<<<log2(N).
  - x = acc >>> log2(N), an arithmetic shift, truncated to WIDTH bits.
- Modulator (updates only on tick_in, using x before its own update):
  - fb = pdm_out ? +2^(WIDTH−1) : −2^(WIDTH−1)
  - i1 (WIDTH+4 bits) += x − fb
  - i2 (WIDTH+8 bits) += i1 − fb
  - Both integrators saturate at their signed limits; no wrap.
  - pdm_out ← (i2_new ≥ 0).
- The modulator runs in every state; in S_IDLE x = 0, which gives ~50% density.

## Timing
- Reset values: pdm_out=0, underrun_out=0, fifo_count_out=0, sample_ready_out=1. Also i1=i2=0, k=0, prev=next=acc=0, state S_IDLE.
- Reset mid-operation: all state and FIFO contents are cleared immediately (asynchronously). Outputs return to reset values without waiting for a clock.
- Push is visible in fifo_count_out the cycle after the handshake.
- pdm_out updates on the clk_in edge where tick_in=1 and is stable between ticks. Maximum one update per tick.
- Sample-to-output latency: a sample pushed into an empty FIFO in S_RUN becomes next at the following boundary, at most TICKS_PER_SAMPLE ticks later. It is fully reached as x one segment after that.
- underrun_out is high exactly for the cycle of the boundary tick.
- tick_in arriving in the same cycle as the S_IDLE→S_RUN transition is consumed with x=0.

## Configuration
- PDM_LINEAR_INTERP_EN defined: linear interpolation between prev and next as above.
- Not defined: zero-order hold. x = prev for the whole segment; acc and delta logic are removed; boundary and FIFO behaviour are identical.

## Test plan
- Reset then idle, no samples, 1024 ticks → pdm_out ones count 512±2, underrun_out never pulses, sample_ready_out=1.
- Push constant +16384 continuously (valid held high), measure ticks 512–767 → ones count 192±2; FIFO fills to 4, ready deasserts, and exactly one pop occurs per 256 ticks.
- Push +32767 continuously → density ≥ 99%, with integrators at or below their saturation limits and no wrap. Push −32768 continuously → density ≤ 1%.
- Push 0 then 8192, with LINEAR_INTERP_EN → during the second segment x steps by 32 per tick (0, 32, …, 8160). Without the macro, x=0 for the whole segment.
- Push a single sample of 4096 then stop → underrun_out pulses once per subsequent boundary; pdm_out density holds at 0.5625±1/256.
- Assert rst_in low mid-segment with 3 samples queued → fifo_count_out=0 and pdm_out=0 immediately. After release: 50% density, and a fresh push resumes from S_IDLE.
